// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF) + 1;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or the restoring divider.
// Multiply: acc holds {partial product, remaining multiplier bits}. Divide: acc[W-1:0] shifts dividend out and quotient in.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 isDiv_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH:0]       rem_i,
    input  logic [WIDTH-1:0]     oper_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [WIDTH:0]       rem_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, oper_i} : '0);
        shifted = {rem_i[WIDTH-1:0], acc_i[WIDTH-1]};
        diff    = shifted - {1'b0, oper_i};
        // A set top bit would already exceed any W-bit divisor.
        fits    = rem_i[WIDTH] | (shifted >= {1'b0, oper_i});
        acc_o   = acc_i;
        rem_o   = rem_i;
        if (isDiv_i) begin
            rem_o              = fits ? diff : shifted;
            acc_o[WIDTH-1:0]   = {acc_i[WIDTH-2:0], fits};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO and MTHI/MTLO.
// Operands are latched as magnitudes; signs are restored in the single FIX cycle.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     oper_q, oper_d;
    logic [WIDTH-1:0]     rawA_q, rawA_d;
    logic                 negRes_q, negRes_d;
    logic                 negRem_q, negRem_d;
    logic                 isDiv_q, isDiv_d;
    logic                 divZero_q, divZero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dzPulse_q, dzPulse_d;

    logic [2*WIDTH-1:0]   stepAcc;
    logic [WIDTH:0]       stepRem;
    logic                 isSignedOp;
    logic                 signA, signB;
    logic [WIDTH-1:0]     magA, magB;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     quotient, remainder;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .isDiv_i (state_q == DIV),
        .acc_i   (acc_q),
        .rem_i   (rem_q),
        .oper_i  (oper_q),
        .acc_o   (stepAcc),
        .rem_o   (stepRem)
    );

    always_comb begin
        isSignedOp = (op == OP_MULT) || (op == OP_DIV);
        signA      = isSignedOp & a[WIDTH-1];
        signB      = isSignedOp & b[WIDTH-1];
        magA       = signA ? -a : a;
        magB       = signB ? -b : b;
        product    = negRes_q ? -acc_q : acc_q;
        quotient   = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        remainder  = negRem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        oper_d    = oper_q;
        rawA_d    = rawA_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        isDiv_d   = isDiv_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dzPulse_d = 1'b0;

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi_d = a;
                            OP_MTLO: lo_d = a;
                            OP_MULT, OP_MULTU: begin
                                acc_d     = {{WIDTH{1'b0}}, magB};
                                oper_d    = magA;
                                rem_d     = '0;
                                rawA_d    = a;
                                negRes_d  = signA ^ signB;
                                negRem_d  = signA;
                                isDiv_d   = 1'b0;
                                divZero_d = 1'b0;
                                cnt_d     = '0;
                                state_d   = MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc_d     = {{WIDTH{1'b0}}, magA};
                                oper_d    = magB;
                                rem_d     = '0;
                                rawA_d    = a;
                                negRes_d  = signA ^ signB;
                                negRem_d  = signA;
                                isDiv_d   = 1'b1;
                                divZero_d = (b == '0);
                                cnt_d     = '0;
                                state_d   = DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    acc_d = stepAcc;
                    rem_d = stepRem;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    if (!isDiv_q) begin
                        hi_d = product[2*WIDTH-1:WIDTH];
                        lo_d = product[WIDTH-1:0];
                    end else if (divZero_q) begin
                        hi_d = rawA_q;
                        lo_d = '1;
                    end else begin
                        hi_d = remainder;
                        lo_d = quotient;
                    end
                    done_d    = 1'b1;
                    dzPulse_d = isDiv_q & divZero_q;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            oper_q    <= '0;
            rawA_q    <= '0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            isDiv_q   <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dzPulse_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            oper_q    <= oper_d;
            rawA_q    <= rawA_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            isDiv_q   <= isDiv_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dzPulse_q <= dzPulse_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dzPulse_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results straight from 64-bit integer arithmetic.
    task automatic computeExpected(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                                   output logic isLong, output logic [31:0] eh, output logic [31:0] el,
                                   output logic edz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        isLong = 1'b0;
        eh     = mHi;
        el     = mLo;
        edz    = 1'b0;
        sa     = $signed(av);
        sb     = $signed(bv);
        case (o)
            3'd0, 3'd1: begin
                isLong = 1'b1;
                if (o == 3'd0) p = 64'(sa * sb);
                else           p = {32'b0, av} * {32'b0, bv};
                eh = p[63:32];
                el = p[31:0];
            end
            3'd2, 3'd3: begin
                isLong = 1'b1;
                if (o == 3'd3) begin
                    sa = longint'({32'b0, av});
                    sb = longint'({32'b0, bv});
                end
                if (bv == 32'd0) begin
                    edz = 1'b1;
                    el  = 32'hFFFF_FFFF;
                    eh  = av;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
            3'd4: eh = av;
            3'd5: el = av;
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input int injectAt);
        logic [31:0] eh, el;
        logic        edz, isLong;
        int          n;
        computeExpected(o, av, bv, isLong, eh, el, edz);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 3'($urandom_range(0, 3));
        if (!isLong) begin
            mHi = eh;
            mLo = el;
            checkOutput("busy_single", 64'(busy), 64'd0);
            checkOutput("done_single", 64'(done), 64'd0);
            checkOutput("hi_single", 64'(hi), 64'(mHi));
            checkOutput("lo_single", 64'(lo), 64'(mLo));
        end else begin
            checkOutput("busy_accept", 64'(busy), 64'd1);
            n = 0;
            while (busy && n < 100) begin
                start = (n == injectAt);
                if (n == 16) checkOutput("done_midop", 64'(done), 64'd0);
                tick();
                n++;
            end
            start = 1'b0;
            mHi = eh;
            mLo = el;
            checkOutput("latency", 64'(n), 64'd33);
            checkOutput("done", 64'(done), 64'd1);
            checkOutput("div_zero", 64'(div_zero), 64'(edz));
            checkOutput("hi", 64'(hi), 64'(eh));
            checkOutput("lo", 64'(lo), 64'(el));
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        #3;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_dz", 64'(div_zero), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        #9 rst_n = 1'b1;
        tick();

        applyStimulus(3'd4, 32'hAAAA_0000, 32'd0, -1);
        applyStimulus(3'd5, 32'h0000_5555, 32'd0, -1);

        // Abort ten cycles into a MULT.
        start = 1'b1; op = 3'd0; a = 32'd1234; b = 32'd5678;
        tick();
        start = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        dones = 0;
        repeat (30) begin
            tick();
            if (done) dones++;
        end
        checkOutput("abort_no_done", 64'(dones), 64'd0);
        checkOutput("abort_hi", 64'(hi), 64'hAAAA_0000);
        checkOutput("abort_lo", 64'(lo), 64'h5555);

        // Abort beats a simultaneous start.
        start = 1'b1; op = 3'd4; a = 32'h1234_5678; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checkOutput("abort_start_hi", 64'(hi), 64'(mHi));
        checkOutput("abort_start_busy", 64'(busy), 64'd0);

        applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5, 5);
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        applyStimulus(3'd3, 32'd100, 32'd7, -1);
        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, -1);
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        applyStimulus(3'd3, 32'h0000_1234, 32'd0, -1);
        applyStimulus(3'd2, 32'hFFFF_FF00, 32'd0, -1);

        // Abort in the FIX cycle suppresses the write.
        start = 1'b1; op = 3'd3; a = 32'd999; b = 32'd10;
        tick();
        start = 1'b0;
        repeat (32) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("fix_abort_done", 64'(done), 64'd0);
        checkOutput("fix_abort_busy", 64'(busy), 64'd0);
        checkOutput("fix_abort_hi", 64'(hi), 64'(mHi));
        checkOutput("fix_abort_lo", 64'(lo), 64'(mLo));

        for (int i = 0; i < 25; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(),
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1);
        end

        // Asynchronous reset in the middle of a DIV.
        start = 1'b1; op = 3'd2; a = 32'd50000; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (15) tick();
        #2 rst_n = 1'b0;
        #1;
        mHi = '0;
        mLo = '0;
        checkOutput("async_rst_busy", 64'(busy), 64'd0);
        checkOutput("async_rst_hi", 64'(hi), 64'd0);
        checkOutput("async_rst_lo", 64'(lo), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        applyStimulus(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer with architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage.
- Handles MULT/MULTU/DIV/DIVU as a 32-iteration shift-add / restoring-divide FSM.
- Exposes start/busy/done so the pipeline stalls MFHI/MFLO and new mult/div ops while an operation is in flight. Also services MTHI/MTLO.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each; iteration count = WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  3  muldiv_pkg::op_t: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; others = no-op
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI,MTLO source)
- b  in  WIDTH  rt operand (divisor / multiplier)
- abort  in  1  pipeline flush; cancels in-flight op
- busy  out  1  operation in flight; pipeline must stall on it
- done  out  1  one-cycle pulse: HI/LO just updated by a mult/div
- div_zero  out  1  one-cycle pulse with done when a DIV/DIVU had b=0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; iteration counter=0. Applies at any point mid-operation, and the in-flight result is discarded.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - start with MTHI/MTLO: hi (resp. lo) <= a at the next edge. Single cycle, busy stays 0, no done.
  - start with MULT*/DIV*: at the next edge, latch |a| and |b| (magnitudes for signed ops, raw values for unsigned) plus the result-sign bits. Counter <= 0, busy <= 1, next state MUL or DIV.
- MUL: one shift-add step per cycle over a 2*WIDTH accumulator. After WIDTH steps, go to FIX.
- DIV: one restoring shift-subtract step per cycle. Remainder register is WIDTH+1 bits. After WIDTH steps, go to FIX.
- FIX (one cycle):
  - Apply sign correction: product is negated if a,b signs differ; quotient is negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo. MULT*: hi=product[2W-1:W], lo=product[W-1:0]. DIV*: lo=quotient, hi=remainder.
  - Assert done for the following cycle, busy <= 0, return to IDLE.
- Latency: start sampled at edge k; hi/lo valid and done=1 after edge k+WIDTH+1 (33 for W=32). busy is high between edges k and k+WIDTH+1.
- Back-to-back: start may be asserted in the same cycle done=1 and is accepted (busy=0).
- start while busy=1: ignored, with no effect on the operation.
- Divide by zero: iterate normally, then force lo=all-ones and hi=a (raw), with div_zero=1 alongside done.
- Signed overflow (-2^(W-1) / -1): lo=0x80000000, hi=0. Results are wrap-around and there is no trap.
- abort=1: from any state, at the next edge go to IDLE with busy=0. hi/lo are unchanged, no done.
- abort together with start in IDLE: abort wins and nothing is latched or written.
- abort in FIX cycle: the write is suppressed.
- a/b are only sampled at accept; later changes have no effect.
- Arithmetic is unsigned internally throughout. Magnitude of -2^(W-1) is 2^(W-1) in W bits, which is correct as unsigned.

Decomposition:
- muldiv_pkg holds:
  - op_t enum (3 bits)
  - state_t enum (IDLE, MUL, DIV, FIX)
  - localparam CNT_W = $clog2(WIDTH)+1
- Sub-module muldiv_step (combinational): given accumulator/remainder, operand and mode, returns the next-iteration value. This keeps the FSM file to control and registers only.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 33 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU a=100, b=7 issued the same cycle done=1 -> accepted; 33 cycles later lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done and div_zero pulse together, lo=0xFFFFFFFF, hi=0x1234.
- MTHI a=0xAAAA0000 then MTLO a=0x5555 -> hi/lo updated in one cycle each with busy=0; start MULT at cycle N, abort at N+10 -> busy=0 at N+11, no done, hi/lo still 0xAAAA0000/0x5555.
- rst_n pulled low mid-DIV (cycle 15) asynchronously -> busy=0, hi=lo=0 immediately; start during busy (cycle 5 of MULT) -> ignored, result matches the original operands.
